sram_access_arbiter: RTL and testbench

//  Sequences the 2Kx16 SRAM array and shares it between two requesters (A, B).

---
 rtl/sram_access_arbiter_if.sv | 31 +++
 rtl/sram_access_arbiter.sv | 105 ++++++++++
 tb/tb_sram_access_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: two request channels (A, B) plus
// the shared read-data and busy status.
interface sram_access_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_ack, b_ack, rdata, busy
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_ack, b_ack, rdata, busy
  );
endinterface

// File: rtl/sram_access_arbiter.sv
// Two-requester round-robin arbiter and SRAM phase sequencer
// (IDLE -> SETUP -> ACCESS x WAIT_CYCLES -> HOLD); every pin is registered.
module sram_access_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  sram_access_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]   sram_adx,
  output logic                sram_cs_n,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  inout  wire  [DATA_W-1:0]   sram_data
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic              last_b, last_b_n;
  logic              op_b, op_b_n;
  logic              op_we, op_we_n;
  logic [ADDR_W-1:0] adx_n;
  logic [DATA_W-1:0] op_wdata, wdata_n;
  logic              drive;
  logic              act_n;

  assign sram_data = drive ? op_wdata : 'z;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_b_n = last_b;
    op_b_n   = op_b;
    op_we_n  = op_we;
    adx_n    = sram_adx;
    wdata_n  = op_wdata;
    case (state)
      IDLE: if (bus.a_req || bus.b_req) begin
        // last_grant only moves on a contested grant
        if (bus.a_req && bus.b_req) begin
          op_b_n   = !last_b;
          last_b_n = !last_b;
        end else begin
          op_b_n = bus.b_req;
        end
        op_we_n = op_b_n ? bus.b_we    : bus.a_we;
        adx_n   = op_b_n ? bus.b_addr  : bus.a_addr;
        wdata_n = op_b_n ? bus.b_wdata : bus.a_wdata;
        state_n = SETUP;
      end
      SETUP: begin
        state_n = ACCESS;
        cnt_n   = 4'(WAIT_CYCLES - 1);
      end
      ACCESS: begin
        if (cnt == 4'd0) state_n = HOLD;
        else             cnt_n   = cnt - 4'd1;
      end
      default: state_n = IDLE;
    endcase
    act_n = (state_n != IDLE);
  end

  // Pin levels are computed from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last_b    <= 1'b1;
      op_b      <= 1'b0;
      op_we     <= 1'b0;
      op_wdata  <= '0;
      sram_adx  <= '0;
      sram_cs_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      drive     <= 1'b0;
      bus.a_ack <= 1'b0;
      bus.b_ack <= 1'b0;
      bus.rdata <= '0;
      bus.busy  <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      last_b    <= last_b_n;
      op_b      <= op_b_n;
      op_we     <= op_we_n;
      op_wdata  <= wdata_n;
      sram_adx  <= adx_n;
      sram_cs_n <= !act_n;
      sram_oe_n <= !(!op_we_n && (state_n == SETUP || state_n == ACCESS));
      sram_we_n <= !(op_we_n && state_n == ACCESS);
      drive     <= op_we_n && act_n;
      bus.a_ack <= (state_n == HOLD) && !op_b_n;
      bus.b_ack <= (state_n == HOLD) && op_b_n;
      bus.busy  <= act_n;
      if (state == ACCESS && cnt == 4'd0 && !op_we)
        bus.rdata <= sram_data;
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: SRAM behavioural model, directed scenarios and
// randomized rounds against a transaction-level arbitration/memory model.
module tb_sram_access_arbiter;
  localparam int AW = 11;
  localparam int DW = 16;
  localparam int W  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // main DUT
  sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  logic [AW-1:0] adx;
  logic          cs_n, oe_n, we_n;
  wire  [DW-1:0] sdata;
  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .sram_adx(adx), .sram_cs_n(cs_n),
    .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_data(sdata));

  logic [DW-1:0] mem     [0:2047];
  logic [DW-1:0] ref_mem [0:2047];
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  assign sdata = (!cs_n && !oe_n) ? mem[adx] : 'z;
  always @(posedge clk)
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (!cs_n && !we_n) mem[adx] <= sdata;

  // WAIT_CYCLES=1 and 15 builds with a read-only pattern SRAM
  sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1();
  sram_access_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus15();
  logic [AW-1:0] adx1, adx15;
  logic          cs1, oe1, we1, cs15, oe15, we15;
  wire  [DW-1:0] sd1, sd15;
  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .sram_adx(adx1), .sram_cs_n(cs1),
    .sram_oe_n(oe1), .sram_we_n(we1), .sram_data(sd1));
  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(15)) dut15 (
    .clk(clk), .rst(rst), .bus(bus15), .sram_adx(adx15), .sram_cs_n(cs15),
    .sram_oe_n(oe15), .sram_we_n(we15), .sram_data(sd15));
  assign sd1  = (!cs1  && !oe1)  ? ({5'b0, adx1}  ^ 16'hC3C3) : 'z;
  assign sd15 = (!cs15 && !oe15) ? ({5'b0, adx15} ^ 16'hC3C3) : 'z;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    tick();
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  // Drives one request and observes it to its ack (bounded); callers judge.
  task automatic xfer(input bit use_b, input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int lat, output logic [DW-1:0] rd,
                      output bit other, output bit overlap);
    lat = -1; rd = '0; other = 0; overlap = 0;
    if (use_b) begin bus.b_we = we; bus.b_addr = a; bus.b_wdata = d; bus.b_req = 1'b1; end
    else       begin bus.a_we = we; bus.a_addr = a; bus.a_wdata = d; bus.a_req = 1'b1; end
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      tick();
      if (!oe_n && !we_n) overlap = 1;
      if (use_b ? bus.a_ack : bus.b_ack) other = 1;
      if (use_b ? bus.b_ack : bus.a_ack) begin lat = k; rd = bus.rdata; end
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (cs_n !== 1'b1) begin bad++; $display("FAIL rst_cs_n got %b want 1", cs_n); end
    total++; if (oe_n !== 1'b1) begin bad++; $display("FAIL rst_oe_n got %b want 1", oe_n); end
    total++; if (we_n !== 1'b1) begin bad++; $display("FAIL rst_we_n got %b want 1", we_n); end
    total++; if (adx !== 11'h0) begin bad++; $display("FAIL rst_adx got %h want 0", adx); end
    total++; if ({bus.a_ack, bus.b_ack, bus.busy} !== 3'b000) begin bad++; $display("FAIL rst_ack_busy got %b want 000", {bus.a_ack, bus.b_ack, bus.busy}); end
    total++; if (bus.rdata !== 16'h0) begin bad++; $display("FAIL rst_rdata got %h want 0", bus.rdata); end
    rst = 1'b0;
    tick();
    preload(11'h100, 16'h0F0F);
    // abort a write in its first ACCESS cycle
    bus.a_we = 1'b1; bus.a_addr = 11'h100; bus.a_wdata = 16'hDEAD; bus.a_req = 1'b1;
    tick(); tick();
    total++; if (we_n !== 1'b0) begin bad++; $display("FAIL pre_abort_we_n got %b want 0", we_n); end
    rst = 1'b1; #1;
    total++; if ({cs_n, oe_n, we_n} !== 3'b111) begin bad++; $display("FAIL abort_pins got %b want 111", {cs_n, oe_n, we_n}); end
    total++; if ({bus.a_ack, bus.busy} !== 2'b00) begin bad++; $display("FAIL abort_ack_busy got %b want 00", {bus.a_ack, bus.busy}); end
    bus.a_req = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (bus.a_ack !== 1'b0) begin bad++; $display("FAIL abort_no_ack cycle %0d got 1 want 0", k); end
    end
    total++; if (mem[11'h100] !== 16'h0F0F) begin bad++; $display("FAIL abort_mem got %h want 0f0f", mem[11'h100]); end
  endtask

  task automatic test_write_read();
    int lat; logic [DW-1:0] rd; bit oth, ovl;
    bus.a_we = 1'b1; bus.a_addr = 11'h005; bus.a_wdata = 16'hBEEF; bus.a_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      total++; if (we_n !== !(k >= 2 && k <= 1 + W)) begin bad++; $display("FAIL wr_we_n cycle N+%0d got %b want %b", k, we_n, !(k >= 2 && k <= 1 + W)); end
      total++; if (bus.a_ack !== (k == 2 + W)) begin bad++; $display("FAIL wr_ack cycle N+%0d got %b want %b", k, bus.a_ack, (k == 2 + W)); end
      if (bus.a_ack) bus.a_req = 1'b0;
    end
    total++; if (mem[11'h005] !== 16'hBEEF) begin bad++; $display("FAIL wr_mem got %h want beef", mem[11'h005]); end
    xfer(0, 0, 11'h005, 16'h0, lat, rd, oth, ovl);
    total++; if (lat !== 2 + W) begin bad++; $display("FAIL rd_latency got %0d want %0d", lat, 2 + W); end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL rd_data got %h want beef", rd); end
    ref_mem[11'h005] = 16'hBEEF;
  endtask

  task automatic test_round_robin();
    int p, last;
    rst = 1'b1; tick(); rst = 1'b0;
    preload(11'h001, 16'h1111);
    preload(11'h002, 16'h2222);
    p = 3 + W;
    last = 2 + W + 3 * p;
    bus.a_we = 1'b0; bus.a_addr = 11'h001; bus.b_we = 1'b0; bus.b_addr = 11'h002;
    bus.a_req = 1'b1; bus.b_req = 1'b1;
    for (int k = 1; k <= last; k++) begin
      tick();
      total++; if (bus.a_ack !== (k == 2 + W || k == 2 + W + 2 * p)) begin bad++; $display("FAIL rr_a_ack cycle N+%0d got %b", k, bus.a_ack); end
      total++; if (bus.b_ack !== (k == 2 + W + p || k == 2 + W + 3 * p)) begin bad++; $display("FAIL rr_b_ack cycle N+%0d got %b", k, bus.b_ack); end
      if (bus.a_ack) begin
        total++; if (bus.rdata !== 16'h1111) begin bad++; $display("FAIL rr_a_rdata got %h want 1111", bus.rdata); end
      end
      if (bus.b_ack) begin
        total++; if (bus.rdata !== 16'h2222) begin bad++; $display("FAIL rr_b_rdata got %h want 2222", bus.rdata); end
      end
      if (k == last) begin bus.a_req = 1'b0; bus.b_req = 1'b0; end
    end
    tick(); tick();
  endtask

  task automatic test_boundary();
    int lat; logic [DW-1:0] rd; bit oth, ovl;
    preload(11'h7FF, 16'h1234);
    xfer(1, 0, 11'h7FF, 16'h0, lat, rd, oth, ovl);
    total++; if (lat !== 2 + W) begin bad++; $display("FAIL b_rd_latency got %0d want %0d", lat, 2 + W); end
    total++; if (rd !== 16'h1234) begin bad++; $display("FAIL b_rd_data got %h want 1234", rd); end
    total++; if (oth !== 1'b0) begin bad++; $display("FAIL b_rd_a_ack got 1 want 0"); end
    total++; if (bus.b_ack !== 1'b0) begin bad++; $display("FAIL b_ack_width got 1 want 0 after pulse"); end
    xfer(0, 1, 11'h000, 16'hA5A5, lat, rd, oth, ovl);
    xfer(0, 1, 11'h7FF, 16'h5A5A, lat, rd, oth, ovl);
    total++; if (mem[11'h000] !== 16'hA5A5) begin bad++; $display("FAIL wr_addr0 got %h want a5a5", mem[11'h000]); end
    total++; if (mem[11'h7FF] !== 16'h5A5A) begin bad++; $display("FAIL wr_addr7ff got %h want 5a5a", mem[11'h7FF]); end
    total++; if (rd !== 16'h1234) begin bad++; $display("FAIL wr_keeps_rdata got %h want 1234", rd); end
    xfer(1, 0, 11'h000, 16'h0, lat, rd, oth, ovl);
    total++; if (rd !== 16'hA5A5) begin bad++; $display("FAIL rd_addr0 got %h want a5a5", rd); end
    ref_mem[11'h000] = 16'hA5A5; ref_mem[11'h7FF] = 16'h5A5A;
  endtask

  task automatic test_latched();
    preload(11'h020, 16'h0BAD);
    bus.a_we = 1'b1; bus.a_addr = 11'h010; bus.a_wdata = 16'h1111; bus.a_req = 1'b1;
    for (int k = 1; k <= 2 + W; k++) begin
      tick();
      if (k == 2) begin bus.a_addr = 11'h020; bus.a_wdata = 16'h2222; end
      if (k >= 2 && k <= 1 + W) begin
        total++; if (adx !== 11'h010) begin bad++; $display("FAIL latch_adx got %h want 010", adx); end
        total++; if (sdata !== 16'h1111) begin bad++; $display("FAIL latch_data got %h want 1111", sdata); end
      end
      if (k == 2 + W) begin
        total++; if (bus.a_ack !== 1'b1) begin bad++; $display("FAIL latch_ack got 0 want 1"); end
      end
    end
    bus.a_req = 1'b0;
    tick();
    total++; if (mem[11'h010] !== 16'h1111) begin bad++; $display("FAIL latch_mem010 got %h want 1111", mem[11'h010]); end
    total++; if (mem[11'h020] !== 16'h0BAD) begin bad++; $display("FAIL latch_mem020 got %h want 0bad", mem[11'h020]); end
    ref_mem[11'h010] = 16'h1111;
  endtask

  task automatic test_wait_variants();
    int lat1 = -1, lat15 = -1;
    logic [DW-1:0] rd1 = '0, rd15 = '0;
    bus1.a_we = 1'b0;  bus1.a_addr = 11'h2AB;  bus1.a_req = 1'b1;
    bus15.a_we = 1'b0; bus15.a_addr = 11'h155; bus15.a_req = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      total++; if ((!oe1 && !we1) || (!oe15 && !we15)) begin bad++; $display("FAIL wait_oe_we_overlap cycle N+%0d", k); end
      if (bus1.a_ack && lat1 < 0)   begin lat1 = k;  rd1 = bus1.rdata;  bus1.a_req = 1'b0; end
      if (bus15.a_ack && lat15 < 0) begin lat15 = k; rd15 = bus15.rdata; bus15.a_req = 1'b0; end
    end
    total++; if (lat1 !== 3) begin bad++; $display("FAIL wait1_latency got %0d want 3", lat1); end
    total++; if (lat15 !== 17) begin bad++; $display("FAIL wait15_latency got %0d want 17", lat15); end
    total++; if (rd1 !== (16'h02AB ^ 16'hC3C3)) begin bad++; $display("FAIL wait1_rdata got %h want %h", rd1, 16'h02AB ^ 16'hC3C3); end
    total++; if (rd15 !== (16'h0155 ^ 16'hC3C3)) begin bad++; $display("FAIL wait15_rdata got %h want %h", rd15, 16'h0155 ^ 16'hC3C3); end
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [16];
    bit lg_b, ra, rb, first_b, cur_b;
    bit we_a, we_b;
    logic [AW-1:0] ad_a, ad_b;
    logic [DW-1:0] wd_a, wd_b, rdm, exp_a, exp_b;
    int t1, t2, ea, eb, mode;
    rst = 1'b1; tick(); rst = 1'b0;
    lg_b = 1'b1; rdm = '0;
    for (int i = 0; i < 16; i++) begin
      pool[i] = (i < 8) ? AW'(i) : AW'(2040 + i - 8);
      preload(pool[i], DW'($urandom));
    end
    t1 = 2 + W; t2 = t1 + 3 + W;
    for (int r = 0; r < 30; r++) begin
      mode = $urandom_range(1, 3);
      ra = mode[0]; rb = mode[1];
      we_a = 1'($urandom_range(0, 1)); ad_a = pool[$urandom_range(0, 15)]; wd_a = DW'($urandom);
      we_b = 1'($urandom_range(0, 1)); ad_b = pool[$urandom_range(0, 15)]; wd_b = DW'($urandom);
      if (ra && rb) begin first_b = !lg_b; lg_b = first_b; end
      else first_b = rb;
      ea = !ra ? -1 : (first_b ? t2 : t1);
      eb = !rb ? -1 : (first_b ? t1 : t2);
      exp_a = rdm; exp_b = rdm;
      for (int s = 0; s < 2; s++) begin
        cur_b = (s == 0) ? first_b : !first_b;
        if (cur_b && rb) begin
          if (we_b) ref_mem[ad_b] = wd_b; else rdm = ref_mem[ad_b];
          exp_b = rdm;
        end else if (!cur_b && ra) begin
          if (we_a) ref_mem[ad_a] = wd_a; else rdm = ref_mem[ad_a];
          exp_a = rdm;
        end
      end
      bus.a_we = we_a; bus.a_addr = ad_a; bus.a_wdata = wd_a; bus.a_req = ra;
      bus.b_we = we_b; bus.b_addr = ad_b; bus.b_wdata = wd_b; bus.b_req = rb;
      for (int k = 1; k <= t2 + 1; k++) begin
        tick();
        total++; if (!oe_n && !we_n) begin bad++; $display("FAIL rnd_oe_we_overlap round %0d cycle %0d", r, k); end
        total++; if (bus.a_ack !== (k == ea)) begin bad++; $display("FAIL rnd_a_ack round %0d cycle %0d got %b want %b", r, k, bus.a_ack, (k == ea)); end
        total++; if (bus.b_ack !== (k == eb)) begin bad++; $display("FAIL rnd_b_ack round %0d cycle %0d got %b want %b", r, k, bus.b_ack, (k == eb)); end
        if (bus.a_ack) begin
          total++; if (bus.rdata !== exp_a) begin bad++; $display("FAIL rnd_a_rdata round %0d got %h want %h", r, bus.rdata, exp_a); end
          bus.a_req = 1'b0;
        end
        if (bus.b_ack) begin
          total++; if (bus.rdata !== exp_b) begin bad++; $display("FAIL rnd_b_rdata round %0d got %h want %h", r, bus.rdata, exp_b); end
          bus.b_req = 1'b0;
        end
      end
      bus.a_req = 1'b0; bus.b_req = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      total++; if (mem[pool[i]] !== ref_mem[pool[i]]) begin bad++; $display("FAIL rnd_mem addr %h got %h want %h", pool[i], mem[pool[i]], ref_mem[pool[i]]); end
    end
  endtask

  initial begin
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = '0; bus1.a_wdata = '0;
    bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = '0; bus1.b_wdata = '0;
    bus15.a_req = 0; bus15.a_we = 0; bus15.a_addr = '0; bus15.a_wdata = '0;
    bus15.b_req = 0; bus15.b_we = 0; bus15.b_addr = '0; bus15.b_wdata = '0;
    test_reset();
    test_write_read();
    test_round_robin();
    test_boundary();
    test_latched();
    test_wait_variants();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
